// File: rtl/contra_sprite_pkg.sv
// -----------------------------------------------------------------------------
// contra_sprite_pkg
// Shared types and defaults for the enemy sprite path.
//   pal_idx_t    : 3-bit palette index carried to the palette stage
//   coord_t      : 10-bit screen coordinate
//   anim_state_t : running-animation FSM states
// -----------------------------------------------------------------------------
package contra_sprite_pkg;

   typedef logic [2:0] pal_idx_t;
   typedef logic [9:0] coord_t;

   localparam int DEF_SPRITE_W = 32;
   localparam int DEF_SPRITE_H = 48;
   localparam int DEF_FRAMES   = 4;
   localparam int ROM_ADDR_W   = 13;

   typedef enum logic {
      ANIM_IDLE = 1'b0,
      ANIM_RUN  = 1'b1
   } anim_state_t;

endpackage

// File: rtl/enemy_anim_fsm.sv
// -----------------------------------------------------------------------------
// enemy_anim_fsm
// Running-animation sequencer. In RUN, counts vsync pulses and steps the
// animation frame every FRAME_DIV pulses. The displayed frame only changes on
// a vsync pulse so a frame never switches mid-screen.
//   Clk, Reset_n  : clock, synchronous active-low reset
//   vsync_pulse   : one-cycle start-of-frame strobe
//   running       : enemy running enable
//   frame         : frame index used by the pixel pipeline
// -----------------------------------------------------------------------------
module enemy_anim_fsm
   import contra_sprite_pkg::*;
#(
   parameter int FRAMES    = DEF_FRAMES,
   parameter int FRAME_DIV = 8,
   parameter int FW        = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic          vsync_pulse,
   input  logic          running,
   output logic [FW-1:0] frame
);

   localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

   anim_state_t   state, state_nxt;
   logic [DW-1:0] div, div_nxt;
   logic [FW-1:0] next_frame, next_frame_nxt;
   logic [FW-1:0] frame_nxt;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_nxt      = state;
      div_nxt        = div;
      next_frame_nxt = next_frame;

      case (state)
         ANIM_IDLE: begin
            div_nxt        = '0;
            next_frame_nxt = '0;
            if (running) state_nxt = ANIM_RUN;
         end
         ANIM_RUN: begin
            if (!running) begin
               // Leaving RUN clears the sequence even if vsync coincides.
               state_nxt      = ANIM_IDLE;
               div_nxt        = '0;
               next_frame_nxt = '0;
            end else if (vsync_pulse) begin
               if (div == DW'(FRAME_DIV - 1)) begin
                  div_nxt        = '0;
                  next_frame_nxt = (next_frame == FW'(FRAMES - 1)) ? '0
                                                                 : next_frame + 1'b1;
               end else begin
                  div_nxt = div + 1'b1;
               end
            end
         end
         default: state_nxt = ANIM_IDLE;
      endcase

      // The displayed frame takes the value next_frame is being updated to,
      // so a step becomes visible on the very pulse that causes it.
      frame_nxt = vsync_pulse ? next_frame_nxt : frame;
   end

   always_ff @(posedge Clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (!Reset_n) begin
         state      <= ANIM_IDLE;
         div        <= '0;
         next_frame <= '0;
         frame      <= '0;
      end else begin
         state      <= state_nxt;
         div        <= div_nxt;
         next_frame <= next_frame_nxt;
         frame      <= frame_nxt;
      end
   end

endmodule

// File: rtl/enemy_sprite_indexer.sv
// -----------------------------------------------------------------------------
// enemy_sprite_indexer
// Maps the current pixel onto the enemy sprite and fetches its palette index
// from an external sprite ROM (1-cycle read latency). Fully pipelined: one
// pixel per cycle, index_valid exactly 2 cycles after pix_valid.
// Build option: define ENEMY_SPRITE_MIRROR_EN to enable horizontal mirroring
// via facing_left; otherwise facing_left is ignored.
//   Clk, Reset_n       : clock, synchronous active-low reset
//   vsync_pulse        : start-of-frame strobe (animation timing)
//   running            : enemy running enable
//   facing_left        : horizontal mirror request
//   enemy_x, enemy_y   : sprite top-left position
//   draw_x, draw_y     : current pixel; pix_valid qualifies it
//   rom_addr, rom_data : sprite ROM address out / palette index back
//   index, index_valid : palette index and its qualifier
//   opaque             : index is a hit and non-transparent
// -----------------------------------------------------------------------------
module enemy_sprite_indexer
   import contra_sprite_pkg::*;
#(
   parameter int SPRITE_W  = DEF_SPRITE_W,
   parameter int SPRITE_H  = DEF_SPRITE_H,
   parameter int FRAMES    = DEF_FRAMES,
   parameter int FRAME_DIV = 8
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        vsync_pulse,
   input  logic        running,
   input  logic        facing_left,
   input  logic [9:0]  enemy_x,
   input  logic [9:0]  enemy_y,
   input  logic [9:0]  draw_x,
   input  logic [9:0]  draw_y,
   input  logic        pix_valid,
   output logic [12:0] rom_addr,
   input  logic [2:0]  rom_data,
   output logic [2:0]  index,
   output logic        index_valid,
   output logic        opaque
);

   localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

   logic [FW-1:0]         frame;
   logic [10:0]           col, row, col_used;
   logic                  hit;
   logic [ROM_ADDR_W-1:0] addr_d;
   logic                  s1_valid, s1_hit, s2_hit;
   pal_idx_t              index_q;

   enemy_anim_fsm #(
      .FRAMES    (FRAMES),
      .FRAME_DIV (FRAME_DIV),
      .FW        (FW)
   ) u_anim (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .vsync_pulse (vsync_pulse),
      .running     (running),
      .frame       (frame)
   );

   // Stage 0: 11-bit unsigned offsets; a pixel left of / above the sprite
   // wraps to a large value and fails the range test.
   always_comb begin
      col = {1'b0, draw_x} - {1'b0, enemy_x};
      row = {1'b0, draw_y} - {1'b0, enemy_y};
      hit = (col < 11'(SPRITE_W)) && (row < 11'(SPRITE_H));
   end

`ifdef ENEMY_SPRITE_MIRROR_EN
   assign col_used = facing_left ? (11'(SPRITE_W - 1) - col) : col;
`else
   logic unused_facing_left;
   assign unused_facing_left = facing_left;
   assign col_used           = col;
`endif

   assign addr_d = ROM_ADDR_W'(frame) * ROM_ADDR_W'(SPRITE_W * SPRITE_H)
                 + ROM_ADDR_W'(row)   * ROM_ADDR_W'(SPRITE_W)
                 + ROM_ADDR_W'(col_used);

   always_ff @(posedge Clk) begin
      // NOTE: the whole pipeline, including the held ROM address, is reset so
      // in-flight pixels are dropped and nothing stale reaches the outputs.
      if (!Reset_n) begin
         rom_addr    <= '0;
         s1_valid    <= 1'b0;
         s1_hit      <= 1'b0;
         index_valid <= 1'b0;
         s2_hit      <= 1'b0;
      end else begin
         s1_valid    <= pix_valid;
         s1_hit      <= pix_valid && hit;
         if (pix_valid && hit) rom_addr <= addr_d;
         index_valid <= s1_valid;
         s2_hit      <= s1_hit;
      end
   end

   // rom_data arrives in the same cycle index_valid is high; misses are
   // forced transparent.
   assign index_q = s2_hit ? rom_data : '0;
   assign index   = index_q;
   assign opaque  = s2_hit && (index_q != '0);

endmodule

// File: tb/tb_enemy_sprite_indexer.sv
// -----------------------------------------------------------------------------
// tb_enemy_sprite_indexer
// Directed bench with a scoreboard: each issued pixel pushes its expected
// index/opaque and due cycle; a negedge monitor pops on index_valid.
// A behavioural ROM returns addr[2:0]+addr[7:5]+addr[11:9] one cycle later.
// -----------------------------------------------------------------------------
module tb_enemy_sprite_indexer;

   typedef struct {
      logic [12:0] addr;
      logic        hit;
      logic [2:0]  idx;
      logic        opq;
      int          cyc;
   } exp_t;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic        vsync_pulse = 1'b0;
   logic        running = 1'b0;
   logic        facing_left = 1'b0;
   logic [9:0]  enemy_x = 10'd100;
   logic [9:0]  enemy_y = 10'd50;
   logic [9:0]  draw_x = '0;
   logic [9:0]  draw_y = '0;
   logic        pix_valid = 1'b0;
   logic [12:0] rom_addr;
   logic [2:0]  rom_data = '0;
   logic [2:0]  index;
   logic        index_valid;
   logic        opaque;

   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   exp_t        sb[$];
   logic [12:0] last_addr = '0;

   enemy_sprite_indexer dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .vsync_pulse (vsync_pulse),
      .running     (running),
      .facing_left (facing_left),
      .enemy_x     (enemy_x),
      .enemy_y     (enemy_y),
      .draw_x      (draw_x),
      .draw_y      (draw_y),
      .pix_valid   (pix_valid),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .index       (index),
      .index_valid (index_valid),
      .opaque      (opaque)
   );

   always #5 Clk = ~Clk;

   function automatic logic [2:0] rom_f(input logic [12:0] a);
      return a[2:0] + a[7:5] + a[11:9];
   endfunction

   always @(posedge Clk) begin
      cyc      <= cyc + 1;
      rom_data <= rom_f(rom_addr);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference pixel model for the default 32x48 sprite.
   function automatic exp_t exp_pixel(input int fr, input int ex, input int ey,
                                      input int dx, input int dy, input bit fl);
      exp_t e;
      int   c, r;
      c = dx - ex;
      r = dy - ey;
      e.hit = (c >= 0) && (c < 32) && (r >= 0) && (r < 48);
`ifdef ENEMY_SPRITE_MIRROR_EN
      if (fl && e.hit) c = 31 - c;
`else
      if (fl) c = c + 0;
`endif
      e.addr = 13'(fr * 1536 + r * 32 + c);
      e.idx  = e.hit ? rom_f(e.addr) : 3'd0;
      e.opq  = (e.idx != 3'd0);
      e.cyc  = 0;
      return e;
   endfunction

   // Scoreboard monitor.
   always @(negedge Clk) begin
      if (index_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_index_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("latency", 32'(cyc), 32'(e.cyc + 2));
            check("index", 32'(index), 32'(e.idx));
            check("opaque", 32'(opaque), 32'(e.opq));
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive_px(input int dx, input int dy, input int fr, input bit push);
      exp_t e;
      draw_x    = 10'(dx);
      draw_y    = 10'(dy);
      pix_valid = 1'b1;
      e = exp_pixel(fr, int'(enemy_x), int'(enemy_y), dx, dy, facing_left);
      e.cyc = cyc;
      if (push) sb.push_back(e);
      if (e.hit) last_addr = e.addr;
   endtask

   task automatic one_px(input int dx, input int dy, input int fr);
      drive_px(dx, dy, fr, 1'b1);
      tick();
      pix_valid = 1'b0;
   endtask

   task automatic vs_pulse();
      vsync_pulse = 1'b1;
      tick();
      vsync_pulse = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      localparam int R = 20;

      // Reset state.
      repeat (3) tick();
      check("rst_rom_addr", 32'(rom_addr), 32'd0);
      check("rst_index", 32'(index), 32'd0);
      check("rst_index_valid", 32'(index_valid), 32'd0);
      check("rst_opaque", 32'(opaque), 32'd0);
      Reset_n = 1'b1;
      tick();

      // Animation: frame steps every 8 pulses, wraps after 4 steps.
      running = 1'b1;
      tick();
      for (int p = 1; p <= 32; p++) begin
         if (p == 24) begin
            // Pixel coincident with the stepping pulse sees the old frame (2).
            vsync_pulse = 1'b1;
            drive_px(100, 50, 2, 1'b1);
            tick();
            vsync_pulse = 1'b0;
            pix_valid   = 1'b0;
            check("coincident_rom_addr", 32'(rom_addr), 32'd3072);
         end else begin
            vs_pulse();
         end
         if ((p % 4 == 0) || (p % 8 == 7) || (p % 8 == 1)) begin
            one_px(100, 50, (p / 8) % 4);
            check("frame_rom_addr", 32'(rom_addr), 32'(((p / 8) % 4) * 1536));
         end
      end

      // Drop running mid-count, with a vsync in the same cycle.
      repeat (7) vs_pulse();
      vsync_pulse = 1'b1;
      running     = 1'b0;
      tick();
      vsync_pulse = 1'b0;
      one_px(100, 50, 0);
      check("idle_clear_rom_addr", 32'(rom_addr), 32'd0);
      running = 1'b1;
      tick();
      for (int p = 1; p <= 8; p++) begin
         vs_pulse();
         if (p >= 7) begin
            one_px(100, 50, (p == 8) ? 1 : 0);
            check("restart_rom_addr", 32'(rom_addr), (p == 8) ? 32'd1536 : 32'd0);
         end
      end
      running = 1'b0;
      tick();

      // Pixel mapping with frame held at 1.
      one_px(100, 50, 1);
      check("origin_rom_addr", 32'(rom_addr), 32'd1536);
      facing_left = 1'b1;
      one_px(100, 50, 1);
`ifdef ENEMY_SPRITE_MIRROR_EN
      check("facing_rom_addr", 32'(rom_addr), 32'd1567);
`else
      check("facing_rom_addr", 32'(rom_addr), 32'd1536);
`endif
      facing_left = 1'b0;
      one_px(131, 97, 1);
      check("last_px_rom_addr", 32'(rom_addr), 32'd3071);
      one_px(105, 50, 1);   // hit whose ROM value is 0: transparent
      check("clear_hit_rom_addr", 32'(rom_addr), 32'd1541);
      one_px(99, 50, 1);
      check("miss_left_hold", 32'(rom_addr), 32'd1541);
      one_px(132, 50, 1);
      check("miss_right_hold", 32'(rom_addr), 32'd1541);
      one_px(100, 98, 1);
      check("miss_below_hold", 32'(rom_addr), 32'd1541);
      one_px(100, 49, 1);
      check("miss_above_hold", 32'(rom_addr), 32'd1541);
      enemy_x = 10'd0;
      enemy_y = 10'd0;
      one_px(1023, 0, 1);
      one_px(0, 0, 1);
      check("edge_origin_rom_addr", 32'(rom_addr), 32'd1536);
      enemy_x = 10'd100;
      enemy_y = 10'd50;
      tick();

      // Back-to-back pixels with a reset pulse in the middle.
      for (int i = 0; i < 64; i++) begin
         Reset_n = (i != R);
         drive_px(96 + (i % 40), 50 + (i % 3), (i <= R) ? 1 : 0,
                  (i != R - 1) && (i != R));
         if (i == R + 1) begin
            check("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
            check("mid_rst_index", 32'(index), 32'd0);
            check("mid_rst_opaque", 32'(opaque), 32'd0);
            check("mid_rst_valid_1", 32'(index_valid), 32'd0);
         end
         if (i == R + 2) check("mid_rst_valid_2", 32'(index_valid), 32'd0);
         tick();
      end
      pix_valid = 1'b0;

      // Drain the scoreboard within a bounded number of cycles.
      for (int k = 0; k < 10 && sb.size() > 0; k++) tick();
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/enemy_sprite_indexer.md
ENEMY_SPRITE_INDEXER -- requirements
Module: enemy_sprite_indexer

Interface
REQ-001 SHALL have parameter SPRITE_W, default 32, sprite width in pixels.
REQ-002 SHALL have parameter SPRITE_H, default 48, sprite height in pixels.
REQ-003 SHALL have parameter FRAMES, default 4, running-animation frame count.
REQ-004 SHALL have parameter FRAME_DIV, default 8, vsync pulses per animation step.
REQ-005 SHALL have one clock, Clk, and a synchronous active-low reset, Reset_n, as the codebase names them.
REQ-006 Ports, in order:
- Clk  in  1  system clock.
- Reset_n  in  1  synchronous active-low reset.
- vsync_pulse  in  1  one-cycle start-of-frame strobe.
- running  in  1  enemy running enable.
- facing_left  in  1  horizontal mirror request.
- enemy_x, enemy_y  in  10 each  sprite top-left position.
- draw_x, draw_y  in  10 each  current pixel.
- pix_valid  in  1  pixel strobe.
- rom_addr  out  13  sprite ROM address.
- rom_data  in  3  ROM palette index, 1-cycle read latency.
- index  out  3  palette index to the palette stage.
- index_valid  out  1  index qualifier.
- opaque  out  1  index is non-transparent.

Function
REQ-007 SHALL run an animation FSM with states IDLE and RUN; IDLE->RUN when running=1, RUN->IDLE when running=0.
REQ-008 In RUN, a divider SHALL count vsync_pulse; on the FRAME_DIV-th pulse it SHALL clear and advance next_frame, wrapping FRAMES-1 -> 0.
REQ-009 On entering IDLE, next_frame and the divider SHALL clear to 0 in the same cycle.
REQ-010 The displayed frame register SHALL load next_frame only on vsync_pulse, with no mid-frame change.
REQ-011 Stage 0 (pix_valid cycle): col=draw_x-enemy_x and row=draw_y-enemy_y, as 11-bit unsigned; hit = col<SPRITE_W and row<SPRITE_H, so negative offsets wrap large and miss.
REQ-012 With mirroring active and facing_left=1, the column used SHALL be SPRITE_W-1-col.
REQ-013 rom_addr SHALL be registered as frame*SPRITE_W*SPRITE_H + row*SPRITE_W + col, truncated to 13 bits; on a miss it SHALL hold its previous value.
REQ-014 index_valid SHALL assert exactly 2 cycles after pix_valid; latency is fixed and the block is fully pipelined, accepting one pixel per cycle.
REQ-015 index SHALL be rom_data on a hit and 0 on a miss; opaque = hit AND index!=0.
REQ-016 When vsync_pulse and pix_valid coincide, the pixel SHALL use the pre-update frame.
REQ-017 A vsync_pulse in the cycle running falls SHALL NOT advance the frame (IDLE clear wins).

Reset
REQ-018 On Reset_n=0 at a Clk edge: FSM=IDLE; frame, next_frame, divider = 0; rom_addr=0; index=0; index_valid=0; opaque=0.
REQ-019 Reset mid-pipeline SHALL discard in-flight pixels; no index_valid for 2 cycles after release.

Configuration
REQ-020 Macro ENEMY_SPRITE_MIRROR_EN defined: REQ-012 mirroring is active.
REQ-021 Macro undefined: facing_left is ignored and no mirror logic is built; the port remains present.

Structure
REQ-022 Package contra_sprite_pkg SHALL hold:
- pal_idx_t (3-bit) and coord_t (10-bit) typedefs.
- Default SPRITE_W, SPRITE_H and FRAMES constants.
- ANIM_IDLE/ANIM_RUN state enum.
REQ-023 The animation FSM, divider and frame registers SHALL be sub-module enemy_anim_fsm; the address/hit pipeline stays in the top.

Verification
REQ-024 Reset, then running=1 with 16 vsync_pulses -> frame goes 0,0..,1 after pulse 8, then 2 after pulse 16.
REQ-025 running=1, 32 vsyncs -> frame wraps 3->0; drop running mid-count -> frame=0, divider=0 next cycle.
REQ-026 enemy=(100,50), draw=(100,50), pix_valid -> rom_addr=frame*1536; index=rom_data, index_valid 2 cycles later.
REQ-027 Mirror build, facing_left=1, draw=(100,50) -> col 31 used, rom_addr=frame*1536+31; non-mirror build -> col 0.
REQ-028 draw=(99,50) or (132,50) -> miss: index=0, opaque=0, index_valid still asserted; rom_data=0 on a hit -> opaque=0.
REQ-029 Back-to-back pix_valid for 64 cycles with Reset_n pulsed at cycle 20 -> outputs zero, index_valid resumes 2 cycles after the next pix_valid.
